// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry width, dispatch/complete/entry
// records and a helper that builds a freshly allocated entry.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_BITS = 4;
  localparam int PC_W          = 32;
  localparam int PREG_W        = 6;
  localparam int DATA_W        = 32;
  localparam int CTRL_W        = 8;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [CTRL_W-1:0] control;
  } dispatchStruct;

  typedef struct packed {
    logic                     valid;
    logic [ROB_SIZE_BITS-1:0] robNum;
    logic [DATA_W-1:0]        result;
  } completeStruct;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [DATA_W-1:0] result;
    logic [CTRL_W-1:0] control;
  } robEntryStruct;

  // A newly allocated entry is valid with a cleared result.
  function automatic robEntryStruct new_entry(dispatchStruct d);
    robEntryStruct e;
    e         = '0;
    e.valid   = 1'b1;
    e.pc      = d.pc;
    e.rd      = d.rd;
    e.rd_old  = d.rd_old;
    e.control = d.control;
    return e;
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Combinational retire selection from the head and head+1 entries.
// Slot b only ever retires behind slot a, and only when DUAL_RETIRE is set.
module rob_retire_select
  import reorder_buffer_pkg::*;
#(
  parameter bit DUAL_RETIRE = 1'b0
) (
  input  robEntryStruct head_entry,
  input  logic          head_done,
  input  robEntryStruct next_entry,
  input  logic          next_done,
  output logic [1:0]    retire_cnt,
  output logic          retire_valid_a,
  output logic          retire_valid_b,
  output robEntryStruct retire_a,
  output robEntryStruct retire_b
);

  // In-order retire: head first, head+1 only as a companion of the head.
  always_comb begin
    retire_valid_a = head_entry.valid && head_done;
    retire_valid_b = DUAL_RETIRE && retire_valid_a && next_entry.valid && next_done;
    retire_a       = retire_valid_a ? head_entry : '0;
    retire_b       = retire_valid_b ? next_entry : '0;
    retire_cnt     = {1'b0, retire_valid_a} + {1'b0, retire_valid_b};
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: 2-wide in-order allocate, 3 completion ports, in-order
// retire. Define ROB_DUAL_RETIRE_EN to allow two retires per cycle;
// otherwise at most one entry retires per cycle and slot b stays zero.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_BITS = reorder_buffer_pkg::ROB_SIZE_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     disp_valid_a,
  input  logic                     disp_valid_b,
  input  dispatchStruct            disp_a,
  input  dispatchStruct            disp_b,
  output logic                     disp_ready,
  output logic [ROB_SIZE_BITS-1:0] disp_rob_num_a,
  output logic [ROB_SIZE_BITS-1:0] disp_rob_num_b,
  input  completeStruct            cpl0,
  input  completeStruct            cpl1,
  input  completeStruct            cpl2,
  output logic                     retire_valid_a,
  output logic                     retire_valid_b,
  output robEntryStruct            retire_a,
  output robEntryStruct            retire_b,
  output logic [ROB_SIZE_BITS:0]   free_count,
  output logic                     empty
);

  localparam int DEPTH = 1 << ROB_SIZE_BITS;
  localparam int PTR_W = ROB_SIZE_BITS + 1;

`ifdef ROB_DUAL_RETIRE_EN
  localparam bit DUAL_RETIRE = 1'b1;
`else
  localparam bit DUAL_RETIRE = 1'b0;
`endif

  robEntryStruct [DEPTH-1:0] entries;
  logic [DEPTH-1:0]          done;

  logic [PTR_W-1:0] head, tail, head_p1, tail_p1, free_q;
  logic [ROB_SIZE_BITS-1:0] head_idx, head_p1_idx, tail_idx, tail_p1_idx;

  logic          accept_a, accept_b;
  logic [1:0]    disp_cnt;
  logic [1:0]    sel_cnt;
  logic          sel_valid_a, sel_valid_b;
  robEntryStruct sel_a, sel_b;
  completeStruct cpl [3];

  assign cpl[0] = cpl0;
  assign cpl[1] = cpl1;
  assign cpl[2] = cpl2;

  assign head_p1     = head + PTR_W'(1);
  assign tail_p1     = tail + PTR_W'(1);
  assign head_idx    = head[ROB_SIZE_BITS-1:0];
  assign head_p1_idx = head_p1[ROB_SIZE_BITS-1:0];
  assign tail_idx    = tail[ROB_SIZE_BITS-1:0];
  assign tail_p1_idx = tail_p1[ROB_SIZE_BITS-1:0];

  // disp_ready looks only at the registered count, so a same-cycle retire
  // cannot open the gate until the next cycle.
  assign disp_ready     = free_q >= PTR_W'(2);
  assign disp_rob_num_a = tail_idx;
  assign disp_rob_num_b = tail_p1_idx;
  assign free_count     = free_q;
  assign empty          = (head == tail);

  // A lone slot b is illegal and is simply not accepted.
  assign accept_a = disp_ready && disp_valid_a;
  assign accept_b = accept_a && disp_valid_b;
  assign disp_cnt = {1'b0, accept_a} + {1'b0, accept_b};

  rob_retire_select #(
    .DUAL_RETIRE (DUAL_RETIRE)
  ) u_retire_select (
    .head_entry     (entries[head_idx]),
    .head_done      (done[head_idx]),
    .next_entry     (entries[head_p1_idx]),
    .next_done      (done[head_p1_idx]),
    .retire_cnt     (sel_cnt),
    .retire_valid_a (sel_valid_a),
    .retire_valid_b (sel_valid_b),
    .retire_a       (sel_a),
    .retire_b       (sel_b)
  );

  // Head/tail pointers and the free-entry count.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      free_q <= PTR_W'(DEPTH);
    end else begin
      head   <= head + PTR_W'(sel_cnt);
      tail   <= tail + PTR_W'(disp_cnt);
      free_q <= free_q - PTR_W'(disp_cnt) + PTR_W'(sel_cnt);
    end
  end

  // Entry storage: allocate, then complete (later port wins), then clear on
  // retire. Allocation targets free slots and retire targets live ones, so
  // the three never collide on a legal cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
      done    <= '0;
    end else begin
      if (accept_a) begin
        entries[tail_idx] <= new_entry(disp_a);
        done[tail_idx]    <= 1'b0;
      end
      if (accept_b) begin
        entries[tail_p1_idx] <= new_entry(disp_b);
        done[tail_p1_idx]    <= 1'b0;
      end
      for (int p = 0; p < 3; p++) begin
        if (cpl[p].valid && entries[cpl[p].robNum].valid) begin
          done[cpl[p].robNum]           <= 1'b1;
          entries[cpl[p].robNum].result <= cpl[p].result;
        end
      end
      if (sel_valid_a) begin
        entries[head_idx].valid <= 1'b0;
        done[head_idx]          <= 1'b0;
      end
      if (sel_valid_b) begin
        entries[head_p1_idx].valid <= 1'b0;
        done[head_p1_idx]          <= 1'b0;
      end
    end
  end

  // Registered retire strobes and payloads toward rename/free-list.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_valid_a <= 1'b0;
      retire_valid_b <= 1'b0;
      retire_a       <= '0;
      retire_b       <= '0;
    end else begin
      retire_valid_a <= sel_valid_a;
      retire_valid_b <= sel_valid_b;
      retire_a       <= sel_a;
      retire_b       <= sel_b;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Reorder buffer for the 2-wide out-of-order core, sitting between dispatch and the retire/free-list logic. It allocates up to two entries per cycle in program order and returns their ROB numbers to the reservation station. It accepts up to three completions per cycle from ALU1, ALU2 and MEM, and retires completed entries in order. Retire returns `rd_old` to rename so the old physical register goes back to the free pool.

## Interface
- `ROB_SIZE_BITS`, default 4: entry index width; depth is 2^ROB_SIZE_BITS (16).
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `disp_valid_a`, `disp_valid_b` in 1 each: dispatch requests; slot a is older.
- `disp_a`, `disp_b` in dispatchStruct: only `pc`, `rd`, `rd_old` and `control` are stored.
- `disp_ready` out 1: the ROB can accept two instructions this cycle.
- `disp_rob_num_a`, `disp_rob_num_b` out ROB_SIZE_BITS: allocated tags, combinational.
- `cpl0`, `cpl1`, `cpl2` in completeStruct: completions from ALU1, ALU2 and MEM. Fields used: `valid`, `robNum`, `result`.
- `retire_valid_a`, `retire_valid_b` out 1: registered retire strobes; slot a is older.
- `retire_a`, `retire_b` out robEntryStruct: retired `pc`, `rd`, `rd_old`, `result`, `control`; registered.
- `free_count` out ROB_SIZE_BITS+1: number of unallocated entries; registered.
- `empty` out 1: no entries allocated.

## Operation
- **Storage:** circular array of entries, each robEntryStruct plus a `done` bit.
- **Pointers:** `head` and `tail`, each ROB_SIZE_BITS+1 wide; the MSB is the wrap bit. Occupancy = tail − head, modulo 2^(ROB_SIZE_BITS+1).
- **Dispatch:**
  - `disp_rob_num_a` = tail[ROB_SIZE_BITS-1:0]; `disp_rob_num_b` = tail+1, low bits.
  - An accepted slot writes its entry with `valid`=1, `done`=0, `result`=0.
  - Tail advances by the number of accepted slots (0, 1 or 2).
  - Accept only when `disp_ready`=1. Valid while not ready is dropped; dispatch stalls upstream.
  - `disp_valid_b` without `disp_valid_a` is illegal: it is ignored and flagged by a bench assertion.
- **`disp_ready`:** registered `free_count` >= 2. It is conservative: a retire in the same cycle does not raise it until the next cycle.
- **Completion:**
  - For each `cplN.valid` whose target entry has `valid`=1, set `done`=1 and store `result`.
  - A completion to an unallocated entry is ignored.
  - Two ports naming the same `robNum` in one cycle is illegal; the highest port index wins.
- **Retire:**
  - Slot a: the head entry has `valid`=1 and `done`=1.
  - Slot b: slot a retires, head+1 also has `valid`=1 and `done`=1, and dual retire is enabled.
  - Retired entries get `valid` and `done` cleared; head advances by the number retired.
- **Simultaneous events:**
  - Dispatch, completion and retire in the same cycle are all legal.
  - free_count_next = free_count − dispatched + retired.
  - A completion and a retire never target the same entry in one cycle, because retire needs `done` set on an earlier edge.
- **Boundaries:**
  - Pointers wrap from entry 2^ROB_SIZE_BITS−1 to 0; wrap bits differ when the buffer is full.
  - Full (free_count = 0): no allocation.
  - Empty: no retire.
- **Reset** (any time, including mid-operation): every entry invalidated, head = tail = 0. Dispatch and completions in the reset cycle are ignored.
- **Reset output values:**
  - `free_count` = 16, `empty` = 1, `disp_ready` = 1.
  - `retire_valid_a/b` = 0, `retire_a/b` all fields 0.
  - `disp_rob_num_a` = 0, `disp_rob_num_b` = 1.

## Timing
- Allocation: the tag is valid combinationally in the dispatch cycle N; the entry is visible from cycle N+1.
- Completion presented in cycle N: `done` set at the end of N. If the entry is at head, `retire_valid_a`=1 during cycle N+2.
- Minimum dispatch-to-retire latency: dispatch in N, complete in N+1, retire strobe in N+3.
- `retire_valid_*` are one-cycle pulses per retired entry. Back-to-back retire every cycle is supported.
- No backpressure on retire: downstream always accepts.

## Configuration
- `ROB_DUAL_RETIRE_EN` defined: up to two retires per cycle, using slot b as described above.
- `ROB_DUAL_RETIRE_EN` undefined: at most one retire per cycle. `retire_valid_b` tied 0 and `retire_b` tied to zeros; head advances by at most 1.

## Structure
- The `typedefs` package carries `ROB_SIZE_BITS`, `robEntryStruct` and `completeStruct`.
- A `done` bit is held alongside each robEntryStruct as local state, not added to the package.
- One sub-module: `rob_retire_select`, a combinational block. It takes the head and head+1 entries and the macro setting, and produces the retire count and retire slot contents.
- Pointer, count and storage logic stay in `reorder_buffer`.

## Test plan
- Reset, then idle: `free_count`=16, `empty`=1, `disp_ready`=1, no retire strobes.
- Dispatch pairs until full: tags 0/1, 2/3 … 14/15. After 8 cycles `free_count`=0 and `disp_ready`=0; a further dispatch is dropped and tail is unchanged.
- Out-of-order completion: complete tag 1 (result 0x11), then tag 0 (0x22) a cycle later. Both retire in order in the same cycle, a=tag0/0x22 and b=tag1/0x11. Without `ROB_DUAL_RETIRE_EN` they retire over two consecutive cycles.
- Three completions in one cycle on tags 0, 1, 2, then retire. `free_count` rises 2 then 1 with dual retire; `rd_old` values match the dispatched ones.
- Wrap-around: run 40 instructions through with continuous dispatch, complete and retire. Tags wrap 15→0, no entry is lost, and the retire order equals the dispatch order.
- Reset asserted with 10 entries live: the next cycle shows `free_count`=16 and `empty`=1, and completions in the reset cycle produce no retire.
